// File: rtl/uart_host_pkg.sv
// Shared types and status-register bit positions for the UART host scheduler.
package uart_host_pkg;

   typedef enum logic [1:0] {
      T_IDLE,
      T_WRITE,
      T_SETTLE
   } tx_state_e;

   typedef enum logic [2:0] {
      R_IDLE,
      R_READ,
      R_WAIT,
      R_HOLD,
      R_SETTLE
   } rx_state_e;

   localparam int ST_ERR_WR     = 0;
   localparam int ST_FULL       = 1;
   localparam int ST_EMPTY      = 2;
   localparam int ST_RX_ERR_LSB = 3;
   localparam int RX_ERR_W      = 4;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, wrapping around.
module uart_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    idx,
   output logic               any
);

   logic [ID_W-1:0] cand;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = ID_W'((32'(ptr) + i) % 32'(NUM_REQ));
         if (!any && req[cand]) begin
            any         = 1'b1;
            idx         = cand;
            grant[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_host_sched.sv
// Host-side scheduler for one uart_protocol: round-robin TX arbitration paced by
// the full flag, and a single-byte-in-flight RX drain into a valid/ready stream.
module uart_host_sched
   import uart_host_pkg::*;
#(
   parameter int DATA_SIZE     = 8,
   parameter int NUM_REQ       = 4,
   parameter int SETTLE_CYCLES = 2,
   parameter int RD_LATENCY    = 1,
   parameter int ID_W          = $clog2(NUM_REQ)
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic [ID_W-1:0]              grant_id,
   output logic                         tx_write,
   output logic [DATA_SIZE-1:0]         tx_data,
   input  logic [7:0]                   tx_status,
   input  logic [7:0]                   rx_status,
   output logic                         rx_read,
   input  logic [DATA_SIZE-1:0]         rx_data_in,
   output logic                         rx_valid,
   output logic [DATA_SIZE-1:0]         rx_data,
   output logic [RX_ERR_W-1:0]          rx_err,
   input  logic                         rx_ready,
   output logic                         tx_busy,
   output logic [7:0]                   drop_cnt
);

   localparam int TCW  = $clog2(SETTLE_CYCLES + 1);
   localparam int RMAX = (SETTLE_CYCLES > RD_LATENCY) ? SETTLE_CYCLES : RD_LATENCY;
   localparam int RCW  = $clog2(RMAX + 1);

   tx_state_e          tx_state;
   logic [TCW-1:0]     tx_cnt;
   logic [ID_W-1:0]    rr_ptr;
   logic               tx_err_seen;
   logic [NUM_REQ-1:0] arb_grant;
   logic [ID_W-1:0]    arb_idx;
   logic               arb_any;
   logic               tx_accept;

   rx_state_e          rx_state;
   logic [RCW-1:0]     rx_cnt;

   logic               unused_status;
   assign unused_status = ^{tx_status[7:2], rx_status[7], rx_status[1:0]};

   uart_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .grant (arb_grant),
      .idx   (arb_idx),
      .any   (arb_any)
   );

   // Acceptance is combinational so the requester sees ready in the cycle its byte is taken.
   assign tx_accept = (tx_state == T_IDLE) && arb_any && !tx_status[ST_FULL];
   assign req_ready = tx_accept ? arb_grant : '0;
   assign tx_busy   = (tx_state != T_IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_state    <= T_IDLE;
         tx_cnt      <= '0;
         rr_ptr      <= '0;
         tx_err_seen <= 1'b0;
         tx_write    <= 1'b0;
         tx_data     <= '0;
         grant_id    <= '0;
         drop_cnt    <= '0;
      end else begin
         case (tx_state)
            T_IDLE: begin
               if (tx_accept) begin
                  tx_data  <= req_data[arb_idx*DATA_SIZE +: DATA_SIZE];
                  grant_id <= arb_idx;
                  rr_ptr   <= (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                  tx_write <= 1'b1;
                  tx_state <= T_WRITE;
               end
            end
            T_WRITE: begin
               tx_write    <= 1'b0;
               tx_cnt      <= TCW'(SETTLE_CYCLES - 1);
               tx_err_seen <= 1'b0;
               tx_state    <= T_SETTLE;
            end
            T_SETTLE: begin
               // One drop per write, however many settle cycles show err_wr.
               if (tx_status[ST_ERR_WR] && !tx_err_seen) begin
                  tx_err_seen <= 1'b1;
                  if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
               end
               if (tx_cnt == '0) tx_state <= T_IDLE;
               else              tx_cnt   <= tx_cnt - 1'b1;
            end
            default: tx_state <= T_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_state <= R_IDLE;
         rx_cnt   <= '0;
         rx_read  <= 1'b0;
         rx_valid <= 1'b0;
         rx_data  <= '0;
         rx_err   <= '0;
      end else begin
         case (rx_state)
            R_IDLE: begin
               if (!rx_status[ST_EMPTY]) begin
                  rx_read  <= 1'b1;
                  rx_state <= R_READ;
               end
            end
            R_READ: begin
               rx_read  <= 1'b0;
               rx_cnt   <= RCW'(RD_LATENCY - 1);
               rx_state <= R_WAIT;
            end
            R_WAIT: begin
               if (rx_cnt == '0) begin
                  rx_data  <= rx_data_in;
                  rx_err   <= rx_status[ST_RX_ERR_LSB +: RX_ERR_W];
                  rx_valid <= 1'b1;
                  rx_state <= R_HOLD;
               end else begin
                  rx_cnt <= rx_cnt - 1'b1;
               end
            end
            R_HOLD: begin
               if (rx_ready) begin
                  rx_valid <= 1'b0;
                  rx_cnt   <= RCW'(SETTLE_CYCLES - 1);
                  rx_state <= R_SETTLE;
               end
            end
            R_SETTLE: begin
               if (rx_cnt == '0) rx_state <= R_IDLE;
               else              rx_cnt   <= rx_cnt - 1'b1;
            end
            default: rx_state <= R_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_host_sched.sv
// Self-checking bench for uart_host_sched: vector table, directed corner sequences,
// and randomized TX/RX traffic against a cycle-level reference model.
module tb_uart_host_sched;

   localparam int DW = 8;
   localparam int NR = 4;
   localparam int SC = 2;
   localparam int RL = 1;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            reset_n;
   logic [NR-1:0]   req_valid;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]   req_ready;
   logic [IW-1:0]   grant_id;
   logic            tx_write;
   logic [DW-1:0]   tx_data;
   logic [7:0]      tx_status;
   logic [7:0]      rx_status;
   logic            rx_read;
   logic [DW-1:0]   rx_data_in;
   logic            rx_valid;
   logic [DW-1:0]   rx_data;
   logic [3:0]      rx_err;
   logic            rx_ready;
   logic            tx_busy;
   logic [7:0]      drop_cnt;

   int n_cmp = 0;
   int n_err = 0;

   logic [11:0] uq[$];    // uart RX FIFO contents {err, data}
   logic [11:0] expq[$];  // RX scoreboard

   typedef struct {
      logic [3:0]  valid;
      logic        full;
      logic [31:0] data;
      logic [3:0]  exp_ready;
      int          exp_id;
      logic [7:0]  exp_byte;
   } vec_t;

   vec_t tbl[12];

   always #5 clk = ~clk;

   uart_host_sched #(
      .DATA_SIZE     (DW),
      .NUM_REQ       (NR),
      .SETTLE_CYCLES (SC),
      .RD_LATENCY    (RL)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .grant_id   (grant_id),
      .tx_write   (tx_write),
      .tx_data    (tx_data),
      .tx_status  (tx_status),
      .rx_status  (rx_status),
      .rx_read    (rx_read),
      .rx_data_in (rx_data_in),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_err     (rx_err),
      .rx_ready   (rx_ready),
      .tx_busy    (tx_busy),
      .drop_cnt   (drop_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock: uart FIFO pops on a sampled read pulse; data is valid only the next cycle.
   task automatic tick();
      logic rd;
      logic [11:0] ent;
      rd = rx_read;
      @(posedge clk);
      #1;
      if (rd && uq.size() > 0) begin
         ent = uq.pop_front();
         rx_data_in     = ent[7:0];
         rx_status[6:3] = ent[11:8];
      end else begin
         rx_data_in     = 8'hEE;
         rx_status[6:3] = 4'hF;
      end
      rx_status[2] = (uq.size() == 0);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset_n    = 1'b0;
      req_valid  = '0;
      req_data   = '0;
      tx_status  = '0;
      rx_status  = 8'h04;
      rx_ready   = 1'b0;
      rx_data_in = '0;
      uq.delete();
      expq.delete();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      int n, extra, writes, cyc, last, reads, got;
      int ptr, g, next_free, wr_cyc, win_lo, win_hi, exp_drop, exp_g;
      bit win_hit, full, err, prev_valid, prev_hs, hs;
      bit [NR-1:0] pend;
      logic [7:0] pd[NR];
      logic [7:0] exp_b, prev_data;
      logic [3:0] prev_err, exp_rdy;
      logic [11:0] ent;

      tbl[0]  = '{4'b0001, 1'b0, 32'h000000A5, 4'b0001, 0, 8'hA5};
      tbl[1]  = '{4'b0001, 1'b0, 32'h00000017, 4'b0001, 0, 8'h17};
      tbl[2]  = '{4'b0100, 1'b1, 32'h00990000, 4'b0000, 0, 8'h00};
      tbl[3]  = '{4'b0100, 1'b0, 32'h00990000, 4'b0100, 2, 8'h99};
      tbl[4]  = '{4'b1011, 1'b0, 32'hD4C3B2A1, 4'b1000, 3, 8'hD4};
      tbl[5]  = '{4'b1011, 1'b0, 32'hD4C3B2A1, 4'b0001, 0, 8'hA1};
      tbl[6]  = '{4'b1011, 1'b0, 32'hD4C3B2A1, 4'b0010, 1, 8'hB2};
      tbl[7]  = '{4'b1011, 1'b0, 32'hD4C3B2A1, 4'b1000, 3, 8'hD4};
      tbl[8]  = '{4'b0000, 1'b0, 32'hFFFFFFFF, 4'b0000, 0, 8'h00};
      tbl[9]  = '{4'b0110, 1'b0, 32'h00556600, 4'b0010, 1, 8'h66};
      tbl[10] = '{4'b0110, 1'b1, 32'h00556600, 4'b0000, 0, 8'h00};
      tbl[11] = '{4'b0110, 1'b0, 32'h00556600, 4'b0100, 2, 8'h55};

      // Reset state
      do_reset();
      check("rst tx_write", tx_write, 0);
      check("rst rx_read", rx_read, 0);
      check("rst rx_valid", rx_valid, 0);
      check("rst drop_cnt", drop_cnt, 0);
      check("rst grant_id", grant_id, 0);
      check("rst tx_data", tx_data, 0);
      check("rst tx_busy", tx_busy, 0);
      check("rst req_ready", req_ready, 0);
      check("rst rx_data", rx_data, 0);
      check("rst rx_err", rx_err, 0);

      // Vector table: arbitration, full pacing, write pulse and settle length
      for (int t = 0; t < 12; t++) begin
         req_valid = tbl[t].valid;
         req_data  = tbl[t].data;
         tx_status = {6'b0, tbl[t].full, 1'b0};
         #1;
         check($sformatf("tbl%0d req_ready", t), req_ready, tbl[t].exp_ready);
         tick();
         req_valid = '0;
         if (tbl[t].exp_ready != 4'b0000) begin
            check($sformatf("tbl%0d tx_write", t), tx_write, 1);
            check($sformatf("tbl%0d tx_data", t), tx_data, tbl[t].exp_byte);
            check($sformatf("tbl%0d grant_id", t), grant_id, tbl[t].exp_id);
            check($sformatf("tbl%0d tx_busy", t), tx_busy, 1);
            n = 0;
            extra = 0;
            do begin
               tick();
               n++;
               if (tx_write) extra++;
            end while (tx_busy && n < 20);
            check($sformatf("tbl%0d settle_len", t), n, SC + 1);
            check($sformatf("tbl%0d pulse_width", t), extra, 0);
            check($sformatf("tbl%0d tx_data_hold", t), tx_data, tbl[t].exp_byte);
         end else begin
            check($sformatf("tbl%0d no_write", t), tx_write, 0);
            check($sformatf("tbl%0d idle", t), tx_busy, 0);
         end
      end

      // Reset in the middle of a write aborts everything
      do_reset();
      uq.push_back({4'h2, 8'h81});
      req_valid = 4'b0001;
      req_data  = 32'h00000011;
      tx_status = 8'h01;
      tick();
      req_valid = '0;
      repeat (4) tick();
      check("abort pre drop_cnt", drop_cnt, 1);
      check("abort pre rx_valid", rx_valid, 1);
      tx_status = 8'h00;
      req_valid = 4'b0100;
      req_data  = 32'h00770000;
      #1;
      check("abort grant", req_ready, 4'b0100);
      tick();
      check("abort in T_WRITE", tx_write, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("abort tx_write", tx_write, 0);
      check("abort drop_cnt", drop_cnt, 0);
      check("abort rx_valid", rx_valid, 0);
      check("abort tx_busy", tx_busy, 0);
      check("abort tx_data", tx_data, 0);
      do_reset();
      req_valid = 4'b1111;
      #1;
      check("abort ptr0", req_ready, 4'b0001);
      req_valid = '0;

      // RX backpressure and re-read spacing
      do_reset();
      uq.push_back({4'h1, 8'h3C});
      uq.push_back({4'h0, 8'h5A});
      reads = 0;
      repeat (12) begin
         if (rx_read) reads++;
         tick();
      end
      check("rx one read", reads, 1);
      check("rx held valid", rx_valid, 1);
      check("rx held data", rx_data, 8'h3C);
      check("rx held err", rx_err, 4'b0001);
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      check("rx valid drop", rx_valid, 0);
      n = 0;
      while (!rx_read && n < 20) begin
         tick();
         n++;
      end
      check("rx reread gap", n, SC + 1);
      n = 0;
      while (!rx_valid && n < 20) begin
         tick();
         n++;
      end
      check("rx second data", rx_data, 8'h5A);
      check("rx second err", rx_err, 4'b0000);
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;

      // Round-robin order, write period, drop_cnt saturation
      do_reset();
      req_valid = 4'b1111;
      req_data  = 32'h33221100;
      tx_status = 8'h01;
      writes = 0;
      last = 0;
      cyc = 0;
      while (writes < 300 && cyc < 2000) begin
         if (tx_write) begin
            writes++;
            if (writes <= 5) begin
               check($sformatf("rr order %0d", writes), grant_id, (writes - 1) % NR);
               check($sformatf("rr data %0d", writes), tx_data, ((writes - 1) % NR) * 17);
            end
            if (writes > 1 && writes <= 6) check("write period", cyc - last, SC + 2);
            last = cyc;
            if (writes == 300) req_valid = '0;
         end
         if (writes < 300) begin
            tick();
            cyc++;
         end
      end
      n = 0;
      while (tx_busy && n < 20) begin
         tick();
         n++;
      end
      check("sat writes", writes, 300);
      check("sat drop_cnt", drop_cnt, 255);
      check("sat idle", tx_busy, 0);

      // Randomized TX against a cycle-level model
      do_reset();
      ptr = 0; next_free = 0; wr_cyc = -1; win_lo = 1; win_hi = 0; win_hit = 0;
      exp_drop = 0; exp_g = 0; exp_b = '0; pend = '0;
      for (int i = 0; i < NR; i++) pd[i] = '0;
      for (int c = 0; c < 1500; c++) begin
         check("rnd tx_write", tx_write, (c == wr_cyc));
         if (c == wr_cyc) begin
            check("rnd tx_data", tx_data, exp_b);
            check("rnd grant_id", grant_id, exp_g);
         end
         check("rnd drop_cnt", drop_cnt, exp_drop);
         for (int i = 0; i < NR; i++) begin
            if (!pend[i]) begin
               if ($urandom_range(1, 0) == 1) begin
                  pend[i] = 1'b1;
                  pd[i]   = 8'($urandom);
               end
            end else if ($urandom_range(7, 0) == 0) begin
               pend[i] = 1'b0;
            end
            req_data[i*DW +: DW] = pd[i];
         end
         req_valid = pend;
         full = ($urandom_range(3, 0) == 0);
         err  = ($urandom_range(5, 0) == 0);
         tx_status = {6'b0, full, err};
         #1;
         g = -1;
         if (c >= next_free && !full) begin
            for (int k = 0; k < NR; k++) begin
               if (g < 0 && pend[(ptr + k) % NR]) g = (ptr + k) % NR;
            end
         end
         exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
         check("rnd req_ready", req_ready, exp_rdy);
         if (c >= win_lo && c <= win_hi && err && !win_hit) begin
            win_hit = 1'b1;
            if (exp_drop < 255) exp_drop++;
         end
         if (g >= 0) begin
            wr_cyc    = c + 1;
            exp_b     = pd[g];
            exp_g     = g;
            ptr       = (g + 1) % NR;
            next_free = c + 2 + SC;
            win_lo    = c + 2;
            win_hi    = c + 1 + SC;
            win_hit   = 1'b0;
            pend[g]   = 1'b0;
         end
         tick();
      end
      req_valid = '0;
      tx_status = '0;

      // Randomized RX stream with random consumer backpressure
      do_reset();
      for (int i = 0; i < 30; i++) begin
         ent = 12'($urandom);
         uq.push_back(ent);
         expq.push_back(ent);
      end
      reads = 0; got = 0; prev_valid = 0; prev_hs = 0; prev_data = '0; prev_err = '0;
      cyc = 0;
      while (got < 30 && cyc < 3000) begin
         if (rx_read) begin
            reads++;
            check("rnd rx read while valid", rx_valid, 0);
         end
         if (prev_valid && !prev_hs) begin
            check("rnd rx hold valid", rx_valid, 1);
            check("rnd rx hold data", rx_data, prev_data);
            check("rnd rx hold err", rx_err, prev_err);
         end
         rx_ready = ($urandom_range(2, 0) == 0);
         hs = rx_valid && rx_ready;
         if (hs) begin
            ent = expq.pop_front();
            check("rnd rx data", rx_data, ent[7:0]);
            check("rnd rx err", rx_err, ent[11:8]);
            got++;
         end
         prev_valid = rx_valid;
         prev_hs    = hs;
         prev_data  = rx_data;
         prev_err   = rx_err;
         tick();
         cyc++;
      end
      rx_ready = 1'b0;
      repeat (6) tick();
      check("rnd rx count", got, 30);
      check("rnd rx reads", reads, 30);
      check("rnd rx drained", rx_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
